// File: rtl/hilo_madd_ctrl.sv
// hilo_madd_ctrl: two-cycle madd/maddu/msub/msubu HI/LO sequencer for the EX stage.
// Define HILO_MSUB_EN to accept msub/msubu; otherwise op_i[1]=1 is ignored.
module hilo_madd_ctrl (
   input  logic        clk,
   input  logic        rst,
   input  logic        op_valid_i,
   input  logic [1:0]  op_i,
   input  logic [31:0] rs_i,
   input  logic [31:0] rt_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        stall_i,
   input  logic        flush_i,
   output logic        stallreq_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o
);
   typedef enum logic [1:0] {IDLE, ACC, HOLD} state_t;
   state_t state;
   logic [63:0] prod, res, hilo, acc, mul, a, b;
   logic ok, start, sx;
   assign sx = !op_i[0];
   assign a = {{32{sx & rs_i[31]}}, rs_i};
   assign b = {{32{sx & rt_i[31]}}, rt_i};
   assign mul = a * b;
   assign hilo = {hi_i, lo_i};
`ifdef HILO_MSUB_EN
   logic sub;
   assign ok = 1'b1;
   assign acc = sub ? hilo - prod : hilo + prod;
`else
   assign ok = !op_i[1];
   assign acc = hilo + prod;
`endif
   // the state is already IDLE under reset, so only the combinational request needs gating
   assign start = op_valid_i && ok && !flush_i && state == IDLE;
   assign stallreq_o = !rst && start;
   assign whilo_o = !flush_i && state != IDLE;
   assign {hi_o, lo_o} = state == ACC ? acc : state == HOLD ? res : 64'd0;
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         prod <= '0;
         res <= '0;
`ifdef HILO_MSUB_EN
         sub <= 1'b0;
`endif
      end else if (flush_i) state <= IDLE;
      else if (start) begin
         state <= ACC;
         prod <= mul;
`ifdef HILO_MSUB_EN
         sub <= op_i[1];
`endif
      end else if (state == ACC) begin
         state <= stall_i ? HOLD : IDLE;
         res <= acc;
      end else if (state == HOLD && !stall_i) state <= IDLE;
endmodule

// File: tb/tb_hilo_madd_ctrl.sv
// tb_hilo_madd_ctrl: directed scoreboard bench for hilo_madd_ctrl.
module tb_hilo_madd_ctrl;
`ifdef HILO_MSUB_EN
   localparam bit MSUB = 1'b1;
`else
   localparam bit MSUB = 1'b0;
`endif
   logic clk = 0, rst = 1, op_valid_i = 0, stall_i = 0, flush_i = 0;
   logic [1:0] op_i = 0;
   logic [31:0] rs_i = 0, rt_i = 0, hi_i = 0, lo_i = 0;
   logic stallreq_o, whilo_o;
   logic [31:0] hi_o, lo_o;
   logic [63:0] q[$];
   int n_cmp = 0, n_err = 0;
   hilo_madd_ctrl dut (
      .clk(clk), .rst(rst), .op_valid_i(op_valid_i), .op_i(op_i), .rs_i(rs_i), .rt_i(rt_i),
      .hi_i(hi_i), .lo_i(lo_i), .stall_i(stall_i), .flush_i(flush_i),
      .stallreq_o(stallreq_o), .whilo_o(whilo_o), .hi_o(hi_o), .lo_o(lo_o)
   );
   always #5 clk = ~clk;
   function automatic logic [63:0] model(input logic [1:0] op, input logic [31:0] rs, rt, hi, lo);
      logic [63:0] p;
      if (op[0]) p = {32'b0, rs} * {32'b0, rt};
      else p = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
      return op[1] ? {hi, lo} - p : {hi, lo} + p;
   endfunction
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask
   // mode: 0 outputs zero, 1 compare to scoreboard head, 2 compare and pop, 3 pop without compare
   task automatic cyc(input string tag, input logic v, input logic [1:0] op, input logic [31:0] rs, rt, hi, lo,
                      input logic st, fl, exp_sr, exp_wh, input int mode);
      @(negedge clk);
      op_valid_i = v; op_i = op; rs_i = rs; rt_i = rt; hi_i = hi; lo_i = lo; stall_i = st; flush_i = fl;
      #1;
      chk({tag, ".stallreq"}, 32'(stallreq_o), 32'(exp_sr));
      chk({tag, ".whilo"}, 32'(whilo_o), 32'(exp_wh));
      if (mode == 0) begin
         chk({tag, ".hi0"}, hi_o, 32'd0);
         chk({tag, ".lo0"}, lo_o, 32'd0);
      end else if (q.size() == 0) begin
         n_cmp++; n_err++;
         $error("FAIL %s.scoreboard: observed empty expected entry", tag);
      end else begin
         if (mode != 3) begin
            chk({tag, ".hi"}, hi_o, q[0][63:32]);
            chk({tag, ".lo"}, lo_o, q[0][31:0]);
         end
         if (mode >= 2) void'(q.pop_front());
      end
      if (exp_sr) q.push_back(model(op, rs, rt, hi, lo));
   endtask
   initial begin
      op_valid_i = 1;
      #2;
      chk("rst.stallreq", 32'(stallreq_o), 0);
      chk("rst.whilo", 32'(whilo_o), 0);
      chk("rst.hi", hi_o, 0);
      chk("rst.lo", lo_o, 0);
      @(negedge clk); rst = 0; op_valid_i = 0;
      cyc("idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("maddu.s", 1, 2'b01, 32'hFFFFFFFF, 2, 0, 1, 0, 0, 1, 0, 0);
      cyc("maddu.a", 1, 2'b01, 32'hFFFFFFFF, 2, 0, 1, 0, 0, 0, 1, 2);
      chk("maddu.hi_const", q.size() == 0 ? 32'h1 : 32'h0, {31'd0, hi_o == 32'h1});
      cyc("madd.s", 1, 2'b00, 32'hFFFFFFFF, 3, 0, 0, 0, 0, 1, 0, 0);
      cyc("madd.a", 1, 2'b00, 32'hFFFFFFFF, 3, 0, 0, 0, 0, 0, 1, 2);
      cyc("msub.s", 1, 2'b10, 2, 5, 0, 32'hA, 0, 0, MSUB, 0, 0);
      cyc("msub.a", 1, 2'b10, 2, 5, 0, 32'hA, 0, 0, 0, MSUB, MSUB ? 2 : 0);
      cyc("msubu.s", 1, 2'b11, 1, 1, 0, 0, 0, 0, MSUB, 0, 0);
      cyc("msubu.a", 1, 2'b11, 1, 1, 0, 0, 0, 0, 0, MSUB, MSUB ? 2 : 0);
      cyc("gap", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("stall.s", 1, 2'b00, 2, 3, 0, 0, 0, 0, 1, 0, 0);
      cyc("stall.acc", 1, 2'b00, 2, 3, 0, 0, 1, 0, 0, 1, 1);
      cyc("stall.h1", 1, 2'b00, 2, 3, 32'h55, 7, 1, 0, 0, 1, 1);
      cyc("stall.h2", 1, 2'b00, 2, 3, 32'h66, 8, 1, 0, 0, 1, 1);
      cyc("stall.h3", 1, 2'b00, 2, 3, 32'h77, 9, 0, 0, 0, 1, 2);
      cyc("stall.idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("istall.s", 1, 2'b01, 4, 5, 0, 1, 1, 0, 1, 0, 0);
      cyc("istall.a", 1, 2'b01, 4, 5, 0, 1, 0, 0, 0, 1, 2);
      cyc("flush.s", 1, 2'b00, 6, 7, 0, 0, 0, 0, 1, 0, 0);
      cyc("flush.acc", 1, 2'b00, 6, 7, 0, 0, 1, 1, 0, 0, 3);
      cyc("flush.idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst.s", 1, 2'b01, 9, 9, 0, 0, 0, 0, 1, 0, 0);
      @(negedge clk); rst = 1;
      #1;
      chk("rstacc.stallreq", 32'(stallreq_o), 0);
      chk("rstacc.whilo", 32'(whilo_o), 0);
      chk("rstacc.hi", hi_o, 0);
      chk("rstacc.lo", lo_o, 0);
      void'(q.pop_front());
      @(negedge clk); rst = 0; op_valid_i = 0;
      cyc("rst.idle", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("b2b.s1", 1, 2'b01, 1, 1, 0, 0, 0, 0, 1, 0, 0);
      cyc("b2b.a1", 1, 2'b01, 1, 1, 0, 0, 0, 0, 0, 1, 2);
      cyc("b2b.s2", 1, 2'b01, 1, 1, 0, 1, 0, 0, 1, 0, 0);
      cyc("b2b.a2", 1, 2'b01, 1, 1, 0, 1, 0, 0, 0, 1, 2);
      cyc("end", 0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("scoreboard.drained", q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/hilo_madd_ctrl.md
# hilo_madd_ctrl

Two-cycle sequencer for the multiply-accumulate class (madd, maddu, msub, msubu) in the OpenMIPS EX stage.
- Cycle 1: registers the 64-bit rs×rt product and requests a pipeline stall.
- Cycle 2: adds or subtracts the product to or from the current HI/LO value and presents the result with a HI/LO write enable.
- The outputs feed the EX/MEM path, which passes hi/lo/whilo on to the HI/LO register through the mem stage.

## Interface
Parameters: none.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  reset; asynchronous, active-high (`RstEnable = 1'b1)
- op_valid_i  in  1  EX holds a madd-class instruction
- op_i  in  2  00 madd, 01 maddu, 10 msub, 11 msubu
- rs_i  in  32  multiplicand
- rt_i  in  32  multiplier
- hi_i  in  32  current HI, already forwarded
- lo_i  in  32  current LO, already forwarded
- stall_i  in  1  a later stage holds EX this cycle
- flush_i  in  1  pipeline flush
- stallreq_o  out  1  stall request to the pipeline controller
- whilo_o  out  1  HI/LO write enable
- hi_o  out  32  result HI
- lo_o  out  32  result LO

## Operation
States: IDLE, ACC, HOLD.

Internal registers:
- prod: 64-bit product.
- res: 64-bit result.

Arithmetic:
- Signed ops (op_i[0]=0): 32×32 signed multiply, sign-extended to 64 bits.
- Unsigned ops (op_i[0]=1): zero-extended operands.
- ACC result = {hi_i,lo_i} + prod for madd/maddu; {hi_i,lo_i} − prod for msub/msubu.
- All arithmetic is modulo 2^64. No overflow detection, no trap.

Transitions:
- IDLE → ACC: op_valid_i && !flush_i && op accepted. Latch prod and the op type.
- ACC → IDLE: !stall_i. ACC → HOLD: stall_i. In both cases latch res with the ACC result.
- HOLD → IDLE: !stall_i.
- flush_i → IDLE from any state. Highest priority after rst.

Outputs:
- stallreq_o = (state==IDLE) && op_valid_i && op accepted && !flush_i. Combinational.
- whilo_o = (state∈{ACC,HOLD}) && !flush_i.
- ACC: hi_o/lo_o come from the combinational ACC result.
- HOLD: hi_o/lo_o come from res, and stay stable even if hi_i/lo_i change.
- IDLE: whilo_o=0, hi_o=lo_o=`ZeroWord.

Other rules:
- While in ACC or HOLD, op_valid_i is the same, already-started instruction. It must not restart the sequence.
- Back-to-back madd-class instructions: the second one is seen in IDLE on the cycle after ACC→IDLE (or HOLD→IDLE). It starts normally.

## Timing
- Latency: result appears 1 cycle after the instruction enters EX.
- stallreq_o is high for exactly one cycle per accepted instruction.
- whilo_o is high for 1 + N cycles, where N is the number of stall_i cycles in ACC/HOLD.
- Reset: state=IDLE and prod=res=0, applied immediately and asynchronously.
- While rst=1, every output is 0: stallreq_o, whilo_o, hi_o, lo_o.
- rst in ACC or HOLD aborts the sequence with no write.
- flush_i in ACC: whilo_o=0 in that same cycle; IDLE on the next cycle.
- stall_i in IDLE does not block the start. The product is captured anyway.

## Configuration
- HILO_MSUB_EN defined: ops 10/11 (msub/msubu) are accepted and subtract.
- HILO_MSUB_EN undefined: op_i[1]=1 is not accepted. The FSM stays in IDLE, and stallreq_o and whilo_o stay 0. Subtract logic is not built.

## Test plan
- maddu: hi_i=0, lo_i=1, rs=0xFFFFFFFF, rt=2.
  - stallreq_o=1 for 1 cycle.
  - Next cycle: whilo_o=1, hi_o=0x00000001, lo_o=0xFFFFFFFF.
- madd signed: hilo=0, rs=0xFFFFFFFF, rt=3.
  - Result: hi_o=0xFFFFFFFF, lo_o=0xFFFFFFFD.
- With HILO_MSUB_EN:
  - msub, hilo=0x0000000A, rs=2, rt=5: result hi=lo=0.
  - msubu, hilo=0, rs=1, rt=1: wraps to hi=lo=0xFFFFFFFF.
- Without HILO_MSUB_EN: msub with the same operands gives stallreq_o=0 and whilo_o=0.
- stall_i held 3 cycles entering ACC, hi_i changed during HOLD:
  - whilo_o=1 for 4 cycles.
  - hi_o/lo_o constant at the ACC value.
  - Returns to IDLE when stall_i drops.
- flush_i in ACC: whilo_o=0 in that cycle, IDLE next cycle.
- rst asserted mid-ACC: all outputs 0 immediately, no write.
- Two consecutive maddu (rs=1, rt=1, hilo forwarded 0 then 1):
  - Two stall pulses.
  - Results hilo=1, then hilo=2.
